muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN cycles, with sign fix-up and single-cycle divide special cases.
module muldiv_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    input  logic            req_valid_i,
    input  logic            mul_en_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] data_1_o,
    output logic [XLEN-1:0] data_2_o
);

    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]  opb;      // multiplicand or divisor magnitude
    logic             res_neg;
    logic             rem_neg;

    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            last;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_step;
    logic [AW-1:0]   prod_fix;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;
    logic [AW-1:0]   div_step;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign accept   = (state == IDLE) && req_valid_i && !flush_i;
    assign div_zero = (rs2_data_i == '0);
    assign div_ovf  = rs1_sign_i && rs2_sign_i && (rs1_data_i == MIN_INT) && (rs2_data_i == '1);
    assign special  = !mul_en_i && (div_zero || div_ovf);
    assign last     = (cnt == CNT_W'(XLEN - 1));

    assign neg1 = rs1_sign_i && rs1_data_i[XLEN-1];
    assign neg2 = rs2_sign_i && rs2_data_i[XLEN-1];
    assign mag1 = neg1 ? -rs1_data_i : rs1_data_i;
    assign mag2 = neg2 ? -rs2_data_i : rs2_data_i;

    // One shift-add step; the carry out of the upper half shifts into the accumulator.
    assign mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_step = {mul_sum, acc[XLEN-1:1]};
    assign prod_fix = res_neg ? -mul_step : mul_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign div_shift = acc[AW-1:XLEN-1];
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_step  = {div_rem, acc[XLEN-2:0], div_ge};
    assign quo_fix   = res_neg ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
    assign rem_fix   = rem_neg ? -div_step[AW-1:XLEN] : div_step[AW-1:XLEN];

    assign busy_o       = accept || (state == MUL) || (state == DIV);
    assign resp_valid_o = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_next = DONE;
                    end else if (mul_en_i) begin
                        state_next = MUL;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result write-back on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            data_1_o <= '0;
            data_2_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        acc     <= {{XLEN{1'b0}}, mag1};
                        opb     <= mag2;
                        res_neg <= neg1 ^ neg2;
                        rem_neg <= neg1;
                        if (special) begin
                            data_1_o <= div_zero ? '1 : MIN_INT;
                            data_2_o <= div_zero ? rs1_data_i : '0;
                        end
                    end
                end
                MUL: begin
                    if (!flush_i) begin
                        acc <= mul_step;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            data_1_o <= prod_fix[XLEN-1:0];
                            data_2_o <= prod_fix[AW-1:XLEN];
                        end
                    end
                end
                DIV: begin
                    if (!flush_i) begin
                        acc <= div_step;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            data_1_o <= quo_fix;
                            data_2_o <= rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
